// File: rtl/mdu_sched.sv
// mdu_sched: multiply/divide unit scheduler for the 5-stage pipeline.
// Owns HI/LO and accepts mult/multu/div/divu from the E stage. The result is
// computed on the accept edge and held as pending. It is committed to HI/LO
// only after the fixed MULT_CYCLES/DIV_CYCLES busy window has elapsed.
// mthi/mtlo write HI/LO directly when idle. Any MDU instruction waiting in D
// is stalled while an operation is starting or in flight.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, mdu_op       E-stage MDU op strobe and opcode
//   rs_val, rt_val      forwarded E-stage operands
//   d_uses_mdu          D-stage instruction touches the MDU
//   hi, lo              architectural HI/LO (registered)
//   busy                operation in flight (registered)
//   stall_d             combinational D-stage stall
module mdu_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_uses_mdu,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_d
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_MTHI  = 4'd3;
    localparam logic [3:0] OP_MTLO  = 4'd4;
    localparam logic [3:0] OP_MULTU = 4'd5;
    localparam logic [3:0] OP_DIVU  = 4'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [31:0]   pend_hi_q, pend_hi_n;
    logic [31:0]   pend_lo_q, pend_lo_n;
    logic          pend_wr_q, pend_wr_n;
    logic [31:0]   hi_n, lo_n;

    logic          is_mul, is_div;
    logic [63:0]   prod_s, prod_u;
    logic          sdiv, div_by_zero;
    logic [31:0]   dvd_mag, dvs_mag, dvs_safe, uq, ur, div_q, div_r;

    assign is_mul = start && ((mdu_op == OP_MULT) || (mdu_op == OP_MULTU));
    assign is_div = start && ((mdu_op == OP_DIV)  || (mdu_op == OP_DIVU));

    // Sign-extended operands give the correct low 64 bits of the signed product.
    assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

    // Signed divide via magnitudes: quotient truncates toward zero, remainder
    // takes the dividend's sign. 0x80000000 / -1 falls out as 0x80000000 r 0.
    assign sdiv        = (mdu_op == OP_DIV);
    assign div_by_zero = (rt_val == 32'd0);
    assign dvd_mag     = (sdiv && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
    assign dvs_mag     = (sdiv && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
    assign dvs_safe    = div_by_zero ? 32'd1 : dvs_mag;
    assign uq          = dvd_mag / dvs_safe;
    assign ur          = dvd_mag % dvs_safe;
    assign div_q       = (sdiv && (rs_val[31] ^ rt_val[31])) ? (~uq + 32'd1) : uq;
    assign div_r       = (sdiv && rs_val[31]) ? (~ur + 32'd1) : ur;

    // Next-state and next-output logic.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        pend_hi_n = pend_hi_q;
        pend_lo_n = pend_lo_q;
        pend_wr_n = pend_wr_q;
        hi_n      = hi;
        lo_n      = lo;
        case (state_q)
            S_IDLE: begin
                if (is_mul) begin
                    state_n   = S_MUL;
                    cnt_n     = CW'(MULT_CYCLES);
                    pend_hi_n = (mdu_op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                    pend_lo_n = (mdu_op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                    pend_wr_n = 1'b1;
                end else if (is_div) begin
                    state_n   = S_DIV;
                    cnt_n     = CW'(DIV_CYCLES);
                    pend_hi_n = div_r;
                    pend_lo_n = div_q;
                    pend_wr_n = !div_by_zero;
                end else if (mdu_op == OP_MTHI) begin
                    hi_n = rs_val;
                end else if (mdu_op == OP_MTLO) begin
                    lo_n = rs_val;
                end
            end
            default: begin
                // Busy: all E-stage MDU requests are ignored until the window closes.
                cnt_n = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_n = S_IDLE;
                    if (pend_wr_q) begin
                        hi_n = pend_hi_q;
                        lo_n = pend_lo_q;
                    end
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            pend_hi_q <= pend_hi_n;
            pend_lo_q <= pend_lo_n;
            pend_wr_q <= pend_wr_n;
            hi        <= hi_n;
            lo        <= lo_n;
            busy      <= (state_n != S_IDLE);
        end
    end

    // Stall must cover the start cycle itself, so it cannot wait for busy.
    assign stall_d = d_uses_mdu & (start | busy);

endmodule

// File: tb/tb_mdu_sched.sv
// tb_mdu_sched: table-driven check of mdu_sched with a result scoreboard,
// plus hand sequences for mthi/mtlo, ignored requests while busy and reset
// in the middle of an operation.
module tb_mdu_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_uses_mdu;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_d;

    mdu_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .mdu_op     (mdu_op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .d_uses_mdu (d_uses_mdu),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .stall_d    (stall_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        d_use;
        logic        preset;
        int          cycles;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    localparam int NVEC = 10;
    vec_t vecs[NVEC];
    res_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Write HI (op 3) or LO (op 4) in idle; starts and ends on a negedge.
    task automatic mt(input logic [3:0] op, input logic [31:0] val);
        mdu_op = op;
        rs_val = val;
        @(negedge clk);
        mdu_op = 4'd0;
        rs_val = 32'd0;
    endtask

    task automatic pop_chk(input string tag);
        res_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_hi"}, hi, e.hi);
            chk({tag, "_lo"}, lo, e.lo);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] oh, ol;
        int n;
        string tag;
        tag = $sformatf("v%0d", idx);
        if (v.preset) begin
            mt(4'd3, 32'h55);
            mt(4'd4, 32'h55);
        end
        oh = hi;
        ol = lo;
        start      = 1'b1;
        mdu_op     = v.op;
        rs_val     = v.rs;
        rt_val     = v.rt;
        d_uses_mdu = v.d_use;
        #1;
        chk({tag, "_stall_start"}, 32'(stall_d), 32'(v.d_use));
        sb.push_back('{hi: v.exp_hi, lo: v.exp_lo});
        @(negedge clk);
        start  = 1'b0;
        mdu_op = 4'd0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            chk({tag, "_stall_busy"}, 32'(stall_d), 32'(v.d_use));
            chk({tag, "_hold_hi"}, hi, oh);
            chk({tag, "_hold_lo"}, lo, ol);
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(v.cycles));
        chk({tag, "_stall_after"}, 32'(stall_d), 32'd0);
        pop_chk(tag);
        d_uses_mdu = 1'b0;
    endtask

    initial begin
        int n;

        vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,         1'b1, 1'b0, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{4'd5, 32'hFFFF_FFFE, 32'd3,         1'b0, 1'b0, 5,  32'h0000_0002, 32'hFFFF_FFFA};
        vecs[2] = '{4'd2, 32'hFFFF_FFF9, 32'd2,         1'b1, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{4'd6, 32'd7,         32'd0,         1'b0, 1'b1, 10, 32'h0000_0055, 32'h0000_0055};
        vecs[4] = '{4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 10, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{4'd6, 32'd100,       32'd7,         1'b0, 1'b0, 10, 32'h0000_0002, 32'h0000_000E};
        vecs[6] = '{4'd2, 32'd7,         32'hFFFF_FFFE, 1'b1, 1'b0, 10, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{4'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0, 5,  32'h3FFF_FFFF, 32'h0000_0001};
        vecs[8] = '{4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 5,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[9] = '{4'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 5,  32'h4000_0000, 32'h0000_0000};

        reset_n    = 1'b0;
        start      = 1'b0;
        mdu_op     = 4'd0;
        rs_val     = 32'd0;
        rt_val     = 32'd0;
        d_uses_mdu = 1'b0;

        // Reset state, then three idle cycles with no change.
        #12;
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall_d), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hi", hi, 32'd0);
        chk("idle_lo", lo, 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Back-to-back mthi/mtlo in idle, busy never rises.
        mdu_op = 4'd3;
        rs_val = 32'h1234;
        @(negedge clk);
        chk("mt_busy0", 32'(busy), 32'd0);
        mdu_op = 4'd4;
        rs_val = 32'hABCD;
        @(negedge clk);
        chk("mt_busy1", 32'(busy), 32'd0);
        mdu_op = 4'd0;
        rs_val = 32'd0;
        chk("mthi", hi, 32'h1234);
        chk("mtlo", lo, 32'hABCD);
        @(negedge clk);
        chk("mt_busy2", 32'(busy), 32'd0);

        // start with a non-mult/div op does nothing.
        start  = 1'b1;
        mdu_op = 4'd7;
        rs_val = 32'hDEAD;
        @(negedge clk);
        start  = 1'b0;
        mdu_op = 4'd0;
        chk("badop_busy", 32'(busy), 32'd0);
        chk("badop_hi", hi, 32'h1234);

        // mult with a second start and an mtlo forced into the busy window.
        start  = 1'b1;
        mdu_op = 4'd1;
        rs_val = 32'hFFFF_FFFE;
        rt_val = 32'd3;
        sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFFA});
        @(negedge clk);
        start  = 1'b0;
        mdu_op = 4'd0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            start  = (n == 2);
            mdu_op = (n == 2) ? 4'd2 : ((n == 3) ? 4'd4 : 4'd0);
            rs_val = (n == 3) ? 32'h9 : 32'd1;
            rt_val = 32'd1;
            @(negedge clk);
        end
        start  = 1'b0;
        mdu_op = 4'd0;
        chk("ign_busy_cycles", 32'(n), 32'd5);
        pop_chk("ign");
        @(negedge clk);
        chk("ign_no_restart", 32'(busy), 32'd0);

        // Reset at busy cycle 4 of a div: cleared immediately, no late write.
        start  = 1'b1;
        mdu_op = 4'd2;
        rs_val = 32'd100;
        rt_val = 32'd3;
        @(negedge clk);
        start  = 1'b0;
        mdu_op = 4'd0;
        repeat (3) @(negedge clk);
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_hi", hi, 32'd0);
        chk("mid_rst_lo", lo, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("late_hi", hi, 32'd0);
        chk("late_lo", lo, 32'd0);
        chk("late_busy", 32'(busy), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
